player_step_ctrl: RTL and testbench
===================================

# player_step_ctrl

Per-frame sequencer for the player movement datapath. On each frame tick it samples the rotate buttons and pulses the player block's `update`. It then waits for the new x/y to settle through the sin/cos and scaling pipeline and asks the wall collision checker about the new position. If the move hits a wall side-on, it pulses `revert` to undo it; if the player is hit head-on, it latches `dead`. It sits between the frame timing generator, the player block and the collision checker.

## Interface
Parameters:
- `SETTLE_CYCLES`, 3: cycles from the `update` pulse until the player x/y outputs reflect the new angle (angle reg → sincos reg → x/y reg).
- `ACK_TIMEOUT`, 255: maximum cycles to wait for `coll_ack` before the result is treated as no hit.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `frame_tick`  in  1  single-cycle pulse, once per frame.
- `enable`  in  1  game running; while low, no new steps start.
- `cw_btn_in`, `ccw_btn_in`  in  1 each  raw, asynchronous buttons.
- `cw_btn`, `ccw_btn`  out  1 each  sampled button levels driven to the player block; held stable for the whole step.
- `update`  out  1  one-cycle pulse to the player block.
- `revert`  out  1  one-cycle pulse to the player block.
- `coll_req`  out  1  collision check request; level, held until ack.
- `coll_ack`  in  1  one-cycle pulse; hit flags are valid in the same cycle.
- `coll_side`  in  1  side hit: the move is illegal and must be undone.
- `coll_front`  in  1  front hit: fatal.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `step_done`  out  1  one-cycle pulse when a step completes.
- `dead`  out  1  sticky; cleared only by `rst`.
- `overrun`  out  1  sticky; set if `frame_tick` arrives while busy.

## Operation
- Button inputs pass through a 2-flop synchronizer. The synchronized levels are captured into `cw_btn`/`ccw_btn` at step start and stay frozen until the next step start.
- If both buttons are pressed, `cw_btn` wins: the controller drives `ccw_btn`=0.
- FSM states are IDLE, UPDATE, SETTLE, CHECK, REVERT and DONE.
  - IDLE → UPDATE when `frame_tick & enable & !dead`. On that edge the buttons are captured.
  - UPDATE: `update`=1 for exactly one cycle, then → SETTLE and the settle counter loads `SETTLE_CYCLES-1`.
  - SETTLE: count down to 0, then → CHECK.
  - CHECK: `coll_req`=1 until `coll_ack`.
    - On ack with `coll_front` → set `dead`, then → DONE. No revert is issued.
    - Else on ack with `coll_side` → REVERT.
    - Else on ack → DONE.
    - If the timeout counter reaches `ACK_TIMEOUT` with no ack → DONE, with no revert.
  - REVERT: `revert`=1 for one cycle, then → DONE.
  - DONE: `step_done`=1 for one cycle, then → IDLE.
- A `frame_tick` while not IDLE sets `overrun` and is otherwise ignored. The tick is not queued.
- If `enable` drops mid-step, the step still completes. `enable` is only sampled in IDLE.
- `update` and `revert` are never high in the same cycle.
- `revert` is issued only after `update` within the same step.

## Timing
- Reset values: all outputs 0; FSM in IDLE; counters 0; synchronizers 0.
- Let T be the cycle in which `frame_tick` is sampled high in IDLE:
  - `update` is high at T+1.
  - SETTLE spans T+2 … T+1+`SETTLE_CYCLES`.
  - `coll_req` first goes high at T+2+`SETTLE_CYCLES`.
- `coll_req` drops in the cycle after the `coll_ack` cycle.
- With an ack in the first CHECK cycle C, and no hit:
  - `step_done` is high at C+1.
  - `busy` is low from C+2.
- With a side hit acked at C: `revert` at C+1, `step_done` at C+2.
- Button change to the captured value: 2 sync cycles, plus capture at the next step start.
- When `rst` is asserted mid-step, the block returns to IDLE at the next edge and `coll_req` drops immediately. The player block has no reset, so its angle is left as-is.
- Timeout counter width is ceil(log2(`ACK_TIMEOUT`+1)). It is cleared on entry to CHECK.

## Structure
- Shared package: the FSM state encoding (3-bit enum) and default constants for `SETTLE_CYCLES` and `ACK_TIMEOUT`. These are shared with the frame timing block's budget checks.
- One natural sub-module: `btn_sync`, a 2-flop synchronizer instantiated per button.
- Everything else is a single FSM plus two down-counters.

## Test plan
- No-hit step, cw held: tick at T → `update`@T+1 with `cw_btn`=1; `coll_req`@T+5 (SETTLE_CYCLES=3); ack with no hit at T+5 → `step_done`@T+6; `revert` never asserted.
- Side hit: ack with `coll_side`=1 at C → `revert`@C+1, `step_done`@C+2; `dead` stays 0.
- Front hit: ack with `coll_front`=1 and `coll_side`=1 → `dead`=1, no `revert`; later ticks leave `busy` at 0.
- Timeout: never ack, `ACK_TIMEOUT`=4 → `coll_req` high for 4 cycles, then `step_done`, no `revert`.
- Overrun and both buttons: tick during SETTLE → `overrun`=1, single `update` only. Both buttons held → `cw_btn`=1, `ccw_btn`=0.
- Reset mid-CHECK: `rst` for one cycle → next cycle IDLE, `coll_req`=0, `dead`=0, `overrun`=0; a following tick starts a clean step.

Source files
------------

// File: rtl/player_step_ctrl_pkg.sv
// Shared state encoding and default timing constants for the player step sequencer.
package player_step_ctrl_pkg;

  localparam int unsigned SETTLE_CYCLES_DEF = 3;
  localparam int unsigned ACK_TIMEOUT_DEF   = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UPDATE = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_REVERT = 3'd4,
    ST_DONE   = 3'd5
  } step_state_t;

endpackage

// File: rtl/player_step_ctrl_btn_sync.sv
// Two-flop synchronizer for one asynchronous button input.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw level through two flops to resolve metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/player_step_ctrl.sv
// Per-frame sequencer: update player, wait for settle, query collision, revert or kill.
module player_step_ctrl
  import player_step_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned ACK_TIMEOUT   = ACK_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic enable,
  input  logic cw_btn_in,
  input  logic ccw_btn_in,
  output logic cw_btn,
  output logic ccw_btn,
  output logic update,
  output logic revert,
  output logic coll_req,
  input  logic coll_ack,
  input  logic coll_side,
  input  logic coll_front,
  output logic busy,
  output logic step_done,
  output logic dead,
  output logic overrun
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned TO_W  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  step_state_t     state;
  logic [SET_W-1:0] settle_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             cw_s;
  logic             ccw_s;

  btn_sync u_cw_sync (
    .clk (clk),
    .rst (rst),
    .d   (cw_btn_in),
    .q   (cw_s)
  );

  btn_sync u_ccw_sync (
    .clk (clk),
    .rst (rst),
    .d   (ccw_btn_in),
    .q   (ccw_s)
  );

  // Step sequencer with registered strobes, button capture and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      to_cnt     <= '0;
      cw_btn     <= 1'b0;
      ccw_btn    <= 1'b0;
      update     <= 1'b0;
      revert     <= 1'b0;
      coll_req   <= 1'b0;
      busy       <= 1'b0;
      step_done  <= 1'b0;
      dead       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      update    <= 1'b0;
      revert    <= 1'b0;
      step_done <= 1'b0;

      // A tick that lands mid-step is dropped but remembered.
      if (frame_tick && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (frame_tick && enable && !dead) begin
            state   <= ST_UPDATE;
            update  <= 1'b1;
            busy    <= 1'b1;
            cw_btn  <= cw_s;
            ccw_btn <= ccw_s & ~cw_s;
          end
        end
        ST_UPDATE: begin
          state      <= ST_SETTLE;
          settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state    <= ST_CHECK;
            coll_req <= 1'b1;
            to_cnt   <= '0;
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        ST_CHECK: begin
          if (coll_ack) begin
            coll_req <= 1'b0;
            if (coll_front) begin
              dead      <= 1'b1;
              state     <= ST_DONE;
              step_done <= 1'b1;
            end else if (coll_side) begin
              state  <= ST_REVERT;
              revert <= 1'b1;
            end else begin
              state     <= ST_DONE;
              step_done <= 1'b1;
            end
          end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
            // No answer from the checker: treat as no hit.
            coll_req  <= 1'b0;
            state     <= ST_DONE;
            step_done <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_REVERT: begin
          state     <= ST_DONE;
          step_done <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          coll_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_step_ctrl.sv
// Randomized scoreboard bench for player_step_ctrl.
module tb_player_step_ctrl;

  localparam int unsigned S = 3;
  localparam int unsigned A = 4;

  localparam logic [2:0] EV_UPD  = 3'd0;
  localparam logic [2:0] EV_RISE = 3'd1;
  localparam logic [2:0] EV_FALL = 3'd2;
  localparam logic [2:0] EV_REV  = 3'd3;
  localparam logic [2:0] EV_DONE = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    int         at;
    logic       cw;
    logic       ccw;
    logic       dd;
  } ev_t;

  logic clk = 1'b0;
  logic rst, frame_tick, enable, cw_btn_in, ccw_btn_in;
  logic coll_ack, coll_side, coll_front;
  logic cw_btn, ccw_btn, update, revert, coll_req, busy, step_done, dead, overrun;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];
  bit   m_dead = 1'b0;
  bit   m_ovr = 1'b0;
  logic prev_req = 1'b0;

  player_step_ctrl #(.SETTLE_CYCLES(S), .ACK_TIMEOUT(A)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .enable     (enable),
    .cw_btn_in  (cw_btn_in),
    .ccw_btn_in (ccw_btn_in),
    .cw_btn     (cw_btn),
    .ccw_btn    (ccw_btn),
    .update     (update),
    .revert     (revert),
    .coll_req   (coll_req),
    .coll_ack   (coll_ack),
    .coll_side  (coll_side),
    .coll_front (coll_front),
    .busy       (busy),
    .step_done  (step_done),
    .dead       (dead),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push(input logic [2:0] kind, input int at, input logic cw, input logic ccw,
                      input logic dd);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.cw   = cw;
    e.ccw  = ccw;
    e.dd   = dd;
    exp_q.push_back(e);
  endtask

  task automatic match(input logic [2:0] kind);
    ev_t act;
    ev_t e;
    act.kind = kind;
    act.at   = cyc;
    act.cw   = cw_btn;
    act.ccw  = ccw_btn;
    act.dd   = dead;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event: got kind=%0d cyc=%0d with nothing expected", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        failures++;
        $display("FAIL event: got kind=%0d cyc=%0d cw=%b ccw=%b dead=%b expected kind=%0d cyc=%0d cw=%b ccw=%b dead=%b",
                 act.kind, act.at, act.cw, act.ccw, act.dd, e.kind, e.at, e.cw, e.ccw, e.dd);
      end
    end
  endtask

  // Monitor: every observable strobe/edge must match the next expected event.
  always @(negedge clk) begin
    if (update)                match(EV_UPD);
    if (coll_req && !prev_req) match(EV_RISE);
    if (!coll_req && prev_req) match(EV_FALL);
    if (revert)                match(EV_REV);
    if (step_done)             match(EV_DONE);
    if (update || revert)      check1("update_revert_exclusive", update & revert, 1'b0);
    prev_req <= coll_req;
  end

  task automatic reset_idle();
    rst = 1'b1;
    next();
    rst = 1'b0;
    m_dead = 1'b0;
    m_ovr  = 1'b0;
    check1("rst_dead", dead, 1'b0);
    check1("rst_overrun", overrun, 1'b0);
    check1("rst_busy", busy, 1'b0);
  endtask

  // One frame: set buttons, tick, then play the collision checker's part.
  task automatic do_step(input bit cw, input bit ccw, input bit en, input int dly,
                         input bit side, input bit front, input bit inj, input bit rst_mid);
    int   t, cs, c, fin;
    bit   go;
    logic ecw, eccw;
    cw_btn_in  = cw;
    ccw_btn_in = ccw;
    enable     = en;
    repeat (4) next();
    t  = cyc;
    go = en && !m_dead;
    frame_tick = 1'b1;
    next();
    frame_tick = 1'b0;
    if (!go) begin
      repeat (S + 4) next();
      check1("idle_busy", busy, 1'b0);
      check1("idle_overrun", overrun, m_ovr);
      check1("idle_dead", dead, m_dead);
      return;
    end
    ecw  = cw;
    eccw = ccw & ~cw;
    cs   = t + 2 + int'(S);
    push(EV_UPD, t + 1, ecw, eccw, 1'b0);
    push(EV_RISE, cs, ecw, eccw, 1'b0);
    check1("busy_start", busy, 1'b1);
    next();
    cw_btn_in  = 1'($urandom_range(0, 1));
    ccw_btn_in = 1'($urandom_range(0, 1));
    enable     = 1'($urandom_range(0, 1));
    if (inj) begin
      next();
      frame_tick = 1'b1;
      m_ovr = 1'b1;
      next();
      frame_tick = 1'b0;
    end
    if (rst_mid) begin
      while (cyc < cs + 1) next();
      rst = 1'b1;
      next();
      rst = 1'b0;
      m_dead = 1'b0;
      m_ovr  = 1'b0;
      push(EV_FALL, cs + 2, 1'b0, 1'b0, 1'b0);
      check1("rstmid_busy", busy, 1'b0);
      check1("rstmid_req", coll_req, 1'b0);
      check1("rstmid_dead", dead, 1'b0);
      check1("rstmid_overrun", overrun, 1'b0);
      check1("rstmid_cw", cw_btn, 1'b0);
      return;
    end
    if (dly < int'(A)) begin
      c = cs + dly;
      while (cyc < c) next();
      check1("req_before_ack", coll_req, 1'b1);
      coll_ack   = 1'b1;
      coll_side  = side;
      coll_front = front;
      next();
      coll_ack   = 1'b0;
      coll_side  = 1'b0;
      coll_front = 1'b0;
      if (front) m_dead = 1'b1;
      push(EV_FALL, c + 1, ecw, eccw, m_dead);
      if (front) begin
        push(EV_DONE, c + 1, ecw, eccw, 1'b1);
        fin = c + 1;
      end else if (side) begin
        push(EV_REV, c + 1, ecw, eccw, 1'b0);
        push(EV_DONE, c + 2, ecw, eccw, 1'b0);
        fin = c + 2;
      end else begin
        push(EV_DONE, c + 1, ecw, eccw, 1'b0);
        fin = c + 1;
      end
    end else begin
      fin = cs + int'(A);
      while (cyc < fin) next();
      push(EV_FALL, fin, ecw, eccw, m_dead);
      push(EV_DONE, fin, ecw, eccw, m_dead);
    end
    while (cyc < fin + 1) next();
    check1("busy_end", busy, 1'b0);
    check1("dead_end", dead, m_dead);
    check1("overrun_end", overrun, m_ovr);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    enable     = 1'b0;
    cw_btn_in  = 1'b0;
    ccw_btn_in = 1'b0;
    coll_ack   = 1'b0;
    coll_side  = 1'b0;
    coll_front = 1'b0;
    repeat (3) next();
    check1("reset_update", update, 1'b0);
    check1("reset_revert", revert, 1'b0);
    check1("reset_req", coll_req, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", step_done, 1'b0);
    check1("reset_dead", dead, 1'b0);
    check1("reset_overrun", overrun, 1'b0);
    check1("reset_cw", cw_btn, 1'b0);
    check1("reset_ccw", ccw_btn, 1'b0);
    rst = 1'b0;
    next();

    do_step(1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_step(1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_step(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_step(1'b0, 1'b0, 1'b1, int'(A), 1'b0, 1'b0, 1'b0, 1'b0);
    do_step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      do_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) != 0), int'($urandom_range(0, 5)),
              (r < 4), (r == 0), ($urandom_range(0, 3) == 0), 1'b0);
      if (m_dead && ($urandom_range(0, 1) == 1)) reset_idle();
    end

    reset_idle();
    do_step(1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    check1("front_dead", dead, 1'b1);
    do_step(1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_idle();
    do_step(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    do_step(1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) next();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events: got %0d left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
